// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
// ddr_pkg : shared lane count, score width and lane-state type for hit_judge.
// Rev 1.0
// ============================================================================
package ddr_pkg;

    localparam int NUM_LANES  = 4;
    localparam int SCORE_W    = 8;
    localparam int LANE_CNT_W = 3;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_OPEN = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_t;

    function automatic logic [LANE_CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [LANE_CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            r = r + LANE_CNT_W'(v[i]);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// key_conditioner : two-flop synchroniser, debounce counter, rising-edge pulse.
// Rev 1.0
// ============================================================================
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = r_sync2 ^ r_deb;
    assign w_accept = w_diff && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_sync2;
            // Any cycle where the synchronised level agrees with the accepted one restarts the count.
            if (!w_diff || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_deb <= r_sync2;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/hit_judge.sv
`default_nettype none
// ============================================================================
// hit_judge : per-lane hit/miss judgement with saturating score and combo.
// Rev 1.0
// ============================================================================
module hit_judge
    import ddr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COMBO_THRESH    = 8,
    parameter int PENALTY_EN      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] pressEnable,
    input  logic [NUM_LANES-1:0] keys,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   combo,
    output logic [NUM_LANES-1:0] hit_pulse,
    output logic [NUM_LANES-1:0] miss_pulse
);

    lane_state_t           r_state      [NUM_LANES];
    lane_state_t           w_state_next [NUM_LANES];
    logic [NUM_LANES-1:0]  w_press;
    logic [NUM_LANES-1:0]  w_hit;
    logic [NUM_LANES-1:0]  w_miss;
    logic [NUM_LANES-1:0]  w_pen;
    logic [SCORE_W-1:0]    r_score;
    logic [SCORE_W-1:0]    r_combo;
    logic [NUM_LANES-1:0]  r_hit;
    logic [NUM_LANES-1:0]  r_miss;

    logic [LANE_CNT_W-1:0] w_n_hits;
    logic [LANE_CNT_W-1:0] w_n_pen;
    logic [LANE_CNT_W:0]   w_gain;
    logic signed [9:0]     w_delta;
    logic signed [9:0]     w_sum;
    logic [SCORE_W:0]      w_combo_sum;
    logic [SCORE_W-1:0]    w_score_next;
    logic [SCORE_W-1:0]    w_combo_next;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_key
            key_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clock   (clock),
                .reset   (reset),
                .key_raw (keys[gi]),
                .press   (w_press[gi])
            );
        end
    endgenerate

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_state_next[l] = r_state[l];
            w_hit[l]        = 1'b0;
            w_miss[l]       = 1'b0;
            w_pen[l]        = 1'b0;
            case (r_state[l])
                LANE_IDLE: begin
                    if (pressEnable[l]) begin
                        w_hit[l]        = w_press[l];
                        w_state_next[l] = w_press[l] ? LANE_DONE : LANE_OPEN;
                    end else begin
                        w_pen[l] = w_press[l] && (PENALTY_EN != 0);
                    end
                end
                LANE_OPEN: begin
                    // A press coinciding with the window closing is swallowed by the miss.
                    if (!pressEnable[l]) begin
                        w_miss[l]       = 1'b1;
                        w_state_next[l] = LANE_IDLE;
                    end else if (w_press[l]) begin
                        w_hit[l]        = 1'b1;
                        w_state_next[l] = LANE_DONE;
                    end
                end
                LANE_DONE: begin
                    if (!pressEnable[l]) begin
                        w_state_next[l] = LANE_IDLE;
                    end
                end
                default: w_state_next[l] = LANE_IDLE;
            endcase
        end
    end

    always_comb begin
        w_n_hits    = popcount(w_hit);
        w_n_pen     = popcount(w_pen);
        w_gain      = (r_combo >= SCORE_W'(COMBO_THRESH)) ? {w_n_hits, 1'b0} : {1'b0, w_n_hits};
        w_delta     = $signed({6'b0, w_gain}) - $signed({7'b0, w_n_pen});
        w_sum       = $signed({2'b0, r_score}) + w_delta;
        w_combo_sum = {1'b0, r_combo} + (SCORE_W + 1)'(w_n_hits);

        if (w_sum < 10'sd0) begin
            w_score_next = '0;
        end else if (w_sum > $signed({2'b0, SCORE_MAX})) begin
            w_score_next = SCORE_MAX;
        end else begin
            w_score_next = w_sum[SCORE_W-1:0];
        end

        if ((|w_miss) || (|w_pen)) begin
            w_combo_next = '0;
        end else if (w_combo_sum[SCORE_W]) begin
            w_combo_next = SCORE_MAX;
        end else begin
            w_combo_next = w_combo_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_state[l] <= LANE_IDLE;
            end
            r_score <= '0;
            r_combo <= '0;
            r_hit   <= '0;
            r_miss  <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_state[l] <= w_state_next[l];
            end
            r_score <= w_score_next;
            r_combo <= w_combo_next;
            r_hit   <= w_hit;
            r_miss  <= w_miss;
        end
    end

    assign score      = r_score;
    assign combo      = r_combo;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;

endmodule
`default_nettype wire
